// File: rtl/cu_sequencer.sv
// cu_sequencer: micro-step sequencer and control-word decoder for the 8-bit
// mini-CPU. Every instruction is a 4-step fetch (opcode byte, operand byte)
// followed by one or two execute steps.
// Optional build macro: CU_ILLEGAL_TRAP_EN. When it is defined, an unlisted
// opcode reaching T4 traps, setting illegal and halted. When it is undefined,
// unlisted opcodes run as NOP and illegal is tied low.
module cu_sequencer #(
   parameter int STEP_W = 4,
   parameter int OPW    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [OPW-1:0]    opcode,
   output logic [STEP_W-1:0] step,
   output logic              SC_reset_next,
   output logic              pc_out,
   output logic              pc_inc,
   output logic              pc_load,
   output logic              mar_in,
   output logic              opcode_in,
   output logic              operand_in,
   output logic              operand_out,
   output logic              RAM_in,
   output logic              RAM_out,
   output logic              regA_in,
   output logic              regA_out,
   output logic              regC_in_enable,
   output logic              regC_out_enable,
   output logic              halted,
   output logic              illegal
);

   localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(5);

   localparam logic [OPW-1:0] OP_NOP = OPW'(8'h00);
   localparam logic [OPW-1:0] OP_LDA = OPW'(8'h01);
   localparam logic [OPW-1:0] OP_STA = OPW'(8'h02);
   localparam logic [OPW-1:0] OP_LDC = OPW'(8'h03);
   localparam logic [OPW-1:0] OP_STC = OPW'(8'h04);
   localparam logic [OPW-1:0] OP_MAC = OPW'(8'h05);
   localparam logic [OPW-1:0] OP_MCA = OPW'(8'h06);
   localparam logic [OPW-1:0] OP_LDI = OPW'(8'h07);
   localparam logic [OPW-1:0] OP_JMP = OPW'(8'h08);
   localparam logic [OPW-1:0] OP_HLT = OPW'(8'hFF);

   // Run/halt state; halted is this state made visible on a port.
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } run_state_t;

   // One bit per datapath strobe, including the end-of-instruction flag.
   typedef struct packed {
      logic sc_reset_next;
      logic pc_out;
      logic pc_inc;
      logic pc_load;
      logic mar_in;
      logic opcode_in;
      logic operand_in;
      logic operand_out;
      logic ram_in;
      logic ram_out;
      logic rega_in;
      logic rega_out;
      logic regc_in;
      logic regc_out;
   } ctl_t;

   run_state_t        state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   ctl_t              raw;    // decoded for the current step, before gating
   ctl_t              ctl;    // gated strobes that reach the ports
   logic              active; // this cycle may strobe and advance
   logic              hold;   // HLT or trap at T4: stop here instead of advancing
   logic              trap;   // unlisted opcode at T4 under the trap build

`ifdef CU_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
`endif

   // State register: step counter, run/halt state and the sticky trap flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_q  <= '0;
         state_q <= ST_RUN;
`ifdef CU_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         step_q  <= step_d;
         state_q <= state_d;
`ifdef CU_ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // Decode the step/opcode into strobes and compute the next step and state.
   always_comb begin
      raw     = '0;
      hold    = 1'b0;
      trap    = 1'b0;
      step_d  = step_q;
      state_d = state_q;
`ifdef CU_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      active  = en & (state_q == ST_RUN) & ~rst;

      case (step_q)
         STEP_W'(0): begin
            raw.pc_out = 1'b1;
            raw.mar_in = 1'b1;
         end
         STEP_W'(1): begin
            raw.ram_out   = 1'b1;
            raw.opcode_in = 1'b1;
            raw.pc_inc    = 1'b1;
         end
         STEP_W'(2): begin
            raw.pc_out = 1'b1;
            raw.mar_in = 1'b1;
         end
         STEP_W'(3): begin
            raw.ram_out    = 1'b1;
            raw.operand_in = 1'b1;
            raw.pc_inc     = 1'b1;
         end
         STEP_W'(4): begin
            case (opcode)
               OP_NOP: raw.sc_reset_next = 1'b1;
               OP_LDA, OP_STA, OP_LDC, OP_STC: begin
                  raw.operand_out = 1'b1;
                  raw.mar_in      = 1'b1;
               end
               OP_MAC: begin
                  raw.rega_out      = 1'b1;
                  raw.regc_in       = 1'b1;
                  raw.sc_reset_next = 1'b1;
               end
               OP_MCA: begin
                  raw.regc_out      = 1'b1;
                  raw.rega_in       = 1'b1;
                  raw.sc_reset_next = 1'b1;
               end
               OP_LDI: begin
                  raw.operand_out   = 1'b1;
                  raw.rega_in       = 1'b1;
                  raw.sc_reset_next = 1'b1;
               end
               OP_JMP: begin
                  raw.operand_out   = 1'b1;
                  raw.pc_load       = 1'b1;
                  raw.sc_reset_next = 1'b1;
               end
               OP_HLT: hold = 1'b1;
               default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                  hold = 1'b1;
                  trap = 1'b1;
`else
                  raw.sc_reset_next = 1'b1;
`endif
               end
            endcase
         end
         STEP_W'(5): begin
            // Only the memory-access opcodes reach T5. Anything else ends
            // the instruction quietly so the sequencer cannot wedge here.
            raw.sc_reset_next = 1'b1;
            case (opcode)
               OP_LDA: begin
                  raw.ram_out = 1'b1;
                  raw.rega_in = 1'b1;
               end
               OP_STA: begin
                  raw.rega_out = 1'b1;
                  raw.ram_in   = 1'b1;
               end
               OP_LDC: begin
                  raw.ram_out = 1'b1;
                  raw.regc_in = 1'b1;
               end
               OP_STC: begin
                  raw.regc_out = 1'b1;
                  raw.ram_in   = 1'b1;
               end
               default: ;
            endcase
         end
         default: ; // corrupted step: no strobes, watchdog recovers below
      endcase

      ctl = raw & {$bits(ctl_t){active}};

      if (active) begin
         if (step_q > STEP_MAX) begin
            step_d = '0;
         end else if (hold) begin
            state_d = ST_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
            if (trap) illegal_d = 1'b1;
`endif
         end else if (raw.sc_reset_next) begin
            step_d = '0;
         end else begin
            step_d = step_q + STEP_W'(1);
         end
      end
   end

   assign step            = step_q;
   assign halted          = (state_q == ST_HALT);
   assign SC_reset_next   = ctl.sc_reset_next;
   assign pc_out          = ctl.pc_out;
   assign pc_inc          = ctl.pc_inc;
   assign pc_load         = ctl.pc_load;
   assign mar_in          = ctl.mar_in;
   assign opcode_in       = ctl.opcode_in;
   assign operand_in      = ctl.operand_in;
   assign operand_out     = ctl.operand_out;
   assign RAM_in          = ctl.ram_in;
   assign RAM_out         = ctl.ram_out;
   assign regA_in         = ctl.rega_in;
   assign regA_out        = ctl.rega_out;
   assign regC_in_enable  = ctl.regc_in;
   assign regC_out_enable = ctl.regc_out;

`ifdef CU_ILLEGAL_TRAP_EN
   assign illegal = illegal_q;
   wire unused_trap = trap;
`else
   assign illegal = 1'b0;
   wire unused_trap = trap;
`endif

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
- Micro-step sequencer and control-word decoder for the 8-bit mini-CPU. It sits upstream of the datapath registers (regA, regC, RAM, PC/MAR, instruction registers) and drives their bus-enable and load strobes.
- It owns the step counter (step) and the end-of-instruction flag (SC_reset_next), both monitored by the on-chip logic analyser.
- Every instruction is a fixed 4-step two-byte fetch (opcode, then operand) followed by 1–2 execute steps.

Parameters:
- STEP_W, 4, step counter width; legal steps 0..5, max 2^STEP_W-1.
- OPW, 8, opcode width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  advance enable; low = freeze step and drive all strobes 0.
- opcode  in  OPW  current opcode from opcode register (valid from step 2).
- step  out  STEP_W  current micro-step.
- SC_reset_next  out  1  high in last step of instruction; step returns to 0 next edge.
- pc_out, pc_inc, pc_load, mar_in  out  1 each  PC/MAR strobes.
- opcode_in, operand_in, operand_out  out  1 each  instruction register strobes.
- RAM_in, RAM_out  out  1 each  RAM write / RAM-to-BUS.
- regA_in, regA_out, regC_in_enable, regC_out_enable  out  1 each  register load / BUS drive.
- halted  out  1  sticky, set by HLT.
- illegal  out  1  sticky illegal-opcode flag (0 unless CU_ILLEGAL_TRAP_EN).

Behaviour:
- Reset: step=0, halted=0, illegal=0. All strobes and SC_reset_next are 0 while rst=1. Reset mid-instruction abandons it with no partial strobe.
- Strobes are combinational from registered step/opcode, ANDed with en & ~halted & ~rst. At most one BUS driver (pc_out, RAM_out, operand_out, regA_out, regC_out_enable) is high in any cycle.
- Step update on edge with en=1: if SC_reset_next then step<=0, else step<=step+1. en=0 holds step.
- Fetch (all opcodes):
  - T0: pc_out, mar_in.
  - T1: RAM_out, opcode_in, pc_inc.
  - T2: pc_out, mar_in.
  - T3: RAM_out, operand_in, pc_inc.
- Execute:
  - NOP 0x00: T4 SC_reset_next only.
  - LDA 0x01: T4 operand_out, mar_in; T5 RAM_out, regA_in, SC_reset_next.
  - STA 0x02: T4 operand_out, mar_in; T5 regA_out, RAM_in, SC_reset_next.
  - LDC 0x03: as LDA with regC_in_enable. STC 0x04: as STA with regC_out_enable.
  - MAC 0x05: T4 regA_out, regC_in_enable, SC_reset_next.
  - MCA 0x06: T4 regC_out_enable, regA_in, SC_reset_next.
  - LDI 0x07: T4 operand_out, regA_in, SC_reset_next.
  - JMP 0x08: T4 operand_out, pc_load, SC_reset_next.
  - HLT 0xFF: at T4 edge with en=1, halted<=1. Step holds at 4 and all strobes stay 0 until rst.
- Unlisted opcodes: executed as NOP (T4 SC_reset_next).
- Step watchdog: if step ever exceeds 5 (corruption), the next enabled edge forces step<=0 with no strobes.
- en deasserted in any step, including the SC_reset_next step: state is frozen, and the same step's strobes reappear when en returns.
- halted has priority over en: once halted=1, en has no effect.

Optional Feature:
- CU_ILLEGAL_TRAP_EN.
- Defined: an unlisted opcode at T4 sets illegal=1 and halted=1 on the next enabled edge. All strobes are 0 in that T4, and step holds. Both flags clear only on rst.
- Undefined: unlisted opcodes behave as NOP, and illegal is tied 0.

Test Plan:
- rst=1 for 3 cycles, then en=1 with opcode 0x00 -> step 0,1,2,3,4,0. SC_reset_next high only at step 4. T0 shows pc_out=mar_in=1.
- LDA (0x01) -> T4 operand_out=mar_in=1; T5 RAM_out=regA_in=SC_reset_next=1; next cycle step=0. Total 6 cycles.
- STC (0x04), then MAC (0x05) -> STC T5 has regC_out_enable=RAM_in=1; MAC T4 has regA_out=regC_in_enable=1. Every cycle checks the single-BUS-driver assertion.
- LDA with en pulsed low for 2 cycles at step 5 -> step stays 5 and strobes are 0 while en=0; on en=1 the T5 strobes reassert once, then step=0.
- HLT (0xFF) -> halted=1 after the T4 edge, step stays 4, strobes 0 for 20 cycles; rst=1 -> step=0, halted=0.
- Opcode 0x3C -> without macro, NOP timing and illegal=0. With CU_ILLEGAL_TRAP_EN, illegal=halted=1 after T4 and no strobes; rst clears both.
